// File: rtl/lutram_fifo_256_if.sv
// Producer/consumer bundle for lutram_fifo_256: write and read requests plus
// the registered occupancy flags, read data and sticky error flags.
interface lutram_fifo_256_if #(
  parameter int WIDTH = 8
);
  // WR_EN/RD_EN are requests sampled on the rising CLK edge. A write is taken
  // when WR_EN & ~FULL and a read when RD_EN & ~EMPTY; RD_DATA carries the
  // popped word from the cycle after the accepted read until the next one.
  logic             WR_EN;
  logic [WIDTH-1:0] WR_DATA;
  logic             FULL;
  logic             ALMOST_FULL;
  logic             RD_EN;
  logic [WIDTH-1:0] RD_DATA;
  logic             EMPTY;
  logic             ALMOST_EMPTY;
  logic [8:0]       COUNT;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  modport master (
    output WR_EN, WR_DATA, RD_EN,
    input  FULL, ALMOST_FULL, RD_DATA, EMPTY, ALMOST_EMPTY, COUNT,
           OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  WR_EN, WR_DATA, RD_EN,
    output FULL, ALMOST_FULL, RD_DATA, EMPTY, ALMOST_EMPTY, COUNT,
           OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/lutram_fifo_256.sv
// 256-deep single-clock FIFO over distributed RAM: synchronous write at
// wr_ptr, asynchronous read at rd_ptr captured into a registered RD_DATA.
module lutram_fifo_256 #(
   parameter int WIDTH      = 8,
   parameter int AFULL_THR  = 240,
   parameter int AEMPTY_THR = 16
) (
   input logic CLK,
   input logic RST_N,
   lutram_fifo_256_if.slave fifo
);

   logic [WIDTH-1:0] mem [256];
   logic [7:0]       wr_ptr;
   logic [7:0]       rd_ptr;
   logic [8:0]       count_q;
   logic [8:0]       count_next;
   logic             full_q;
   logic             empty_q;
   logic             wr_acc;
   logic             rd_acc;

   always_comb begin
      wr_acc     = fifo.WR_EN & ~full_q;
      rd_acc     = fifo.RD_EN & ~empty_q;
      count_next = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_next = count_q + 9'd1;
         2'b01:   count_next = count_q - 9'd1;
         default: count_next = count_q;
      endcase
   end

   // Storage is never reset; reset only discards entries by clearing pointers.
   always_ff @(posedge CLK) begin
      if (RST_N && wr_acc) mem[wr_ptr] <= fifo.WR_DATA;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr            <= 8'd0;
         rd_ptr            <= 8'd0;
         count_q           <= 9'd0;
         full_q            <= 1'b0;
         empty_q           <= 1'b1;
         fifo.ALMOST_FULL  <= 1'b0;
         fifo.ALMOST_EMPTY <= 1'b1;
         fifo.RD_DATA      <= '0;
         fifo.OVERFLOW     <= 1'b0;
         fifo.UNDERFLOW    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 8'd1;
         if (rd_acc) begin
            fifo.RD_DATA <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 8'd1;
         end
         count_q           <= count_next;
         full_q            <= (count_next == 9'd256);
         empty_q           <= (count_next == 9'd0);
         fifo.ALMOST_FULL  <= (count_next >= 9'(AFULL_THR));
         fifo.ALMOST_EMPTY <= (count_next <= 9'(AEMPTY_THR));
         if (fifo.WR_EN && full_q)  fifo.OVERFLOW  <= 1'b1;
         if (fifo.RD_EN && empty_q) fifo.UNDERFLOW <= 1'b1;
      end
   end

   assign fifo.COUNT = count_q;
   assign fifo.FULL  = full_q;
   assign fifo.EMPTY = empty_q;

endmodule

// File: tb/tb_lutram_fifo_256.sv
// Directed bench for lutram_fifo_256: a queue model predicts occupancy and
// flags each cycle; a monitor checks popped data against an expected queue.
module tb_lutram_fifo_256;
  localparam int W = 8;

  logic CLK;
  logic RST_N;
  lutram_fifo_256_if #(.WIDTH(W)) bus ();

  lutram_fifo_256 #(.WIDTH(W), .AFULL_THR(240), .AEMPTY_THR(16)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .fifo (bus.slave)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // model and scoreboard state
  logic [W-1:0] m_q[$];
  logic [W-1:0] exp_q[$];
  bit m_ovf;
  bit m_unf;
  bit rd_fire;
  int n_tests;
  int n_fail;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = m_q.size();
    check("count",        int'(bus.COUNT), sz);
    check("empty",        int'(bus.EMPTY), int'(sz == 0));
    check("full",         int'(bus.FULL), int'(sz == 256));
    check("almost_full",  int'(bus.ALMOST_FULL), int'(sz >= 240));
    check("almost_empty", int'(bus.ALMOST_EMPTY), int'(sz <= 16));
    check("overflow",     int'(bus.OVERFLOW), int'(m_ovf));
    check("underflow",    int'(bus.UNDERFLOW), int'(m_unf));
  endtask

  // driver: one clock with the given inputs, model updated from the
  // pre-edge occupancy, state checked #1 after the edge
  task automatic cycle(input bit rst, input bit we, input logic [W-1:0] wd, input bit re);
    bit wa;
    bit ra;
    bit was_full;
    bit was_empty;
    @(negedge CLK);
    RST_N       = ~rst;
    bus.WR_EN   = we;
    bus.WR_DATA = wd;
    bus.RD_EN   = re;
    was_full  = (m_q.size() == 256);
    was_empty = (m_q.size() == 0);
    wa = !rst && we && !was_full;
    ra = !rst && re && !was_empty;
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (ra) exp_q.push_back(m_q.pop_front());
      if (wa) m_q.push_back(wd);
      if (we && was_full)  m_ovf = 1'b1;
      if (re && was_empty) m_unf = 1'b1;
    end
    rd_fire = ra;
    @(posedge CLK);
    #1;
    check_state();
  endtask

  // monitor: compares RD_DATA after every edge that accepted a read
  initial begin
    forever begin
      @(posedge CLK);
      if (rd_fire) begin
        #1;
        if (exp_q.size() == 0) begin
          check("rd_data_unexpected", 1, 0);
        end else begin
          check("rd_data", int'(bus.RD_DATA), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rd_fire = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    RST_N       = 1'b0;
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = '0;
    bus.RD_EN   = 1'b0;

    // reset then idle
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 0);
    check("reset_rd_data", int'(bus.RD_DATA), 0);

    // five writes then five reads
    for (int i = 1; i <= 5; i++) cycle(0, 1, W'(i), 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1);

    // fill completely, overflow, drain in order
    for (int i = 0; i < 256; i++) cycle(0, 1, W'(i & 8'hFF), 0);
    cycle(0, 1, 8'h77, 0);
    for (int i = 0; i < 256; i++) cycle(0, 0, 8'h00, 1);

    // full with simultaneous write and read
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 256; i++) cycle(0, 1, W'((i + 8'h10) & 8'hFF), 0);
    cycle(0, 1, 8'hEE, 1);
    for (int i = 0; i < 255; i++) cycle(0, 0, 8'h00, 1);

    // empty with simultaneous write and read: no bypass
    cycle(1, 0, 8'h00, 0);
    cycle(0, 1, 8'hA5, 1);
    check("no_bypass_rd_hold", int'(bus.RD_DATA), 0);
    cycle(0, 0, 8'h00, 1);

    // pointer wrap with one-entry lag
    cycle(1, 0, 8'h00, 0);
    cycle(0, 1, 8'h3C, 0);
    for (int i = 0; i < 300; i++) cycle(0, 1, W'((i * 7 + 3) & 8'hFF), 1);
    cycle(0, 0, 8'h00, 1);

    // reset discards a partially filled FIFO
    for (int i = 0; i < 100; i++) cycle(0, 1, W'(i), 0);
    check("count_before_reset", int'(bus.COUNT), 100);
    cycle(1, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    check("reset_rd_data_after", int'(bus.RD_DATA), 0);

    repeat (3) @(posedge CLK);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lutram_fifo_256.md
Name: lutram_fifo_256

Overview:
Synchronous single-clock FIFO that wraps 256-deep, WIDTH-bit distributed-RAM storage. Each storage bit slice has the same behaviour as one 256x1 dual-port LUT RAM: a synchronous write port, with the write pointer driving the shared read/write address, and an asynchronous read port driven by the read pointer. The block sits directly upstream of the LUT RAM: it generates the write enable, write address and read address, and registers the asynchronous read data. Intended as the standard small buffer between Verilator-simulated Xilinx designs' producer and consumer logic.

Parameters:
WIDTH, 8, data width in bits (1..64); one 256x1 storage slice per bit
AFULL_THR, 240, ALMOST_FULL asserts when COUNT >= AFULL_THR (1..255)
AEMPTY_THR, 16, ALMOST_EMPTY asserts when COUNT <= AEMPTY_THR (0..254)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  synchronous active-low reset
WR_EN  input  1  write request
WR_DATA  input  WIDTH  write data
FULL  output  1  FIFO holds 256 entries
ALMOST_FULL  output  1  COUNT >= AFULL_THR
RD_EN  input  1  read request
RD_DATA  output  WIDTH  registered read data
EMPTY  output  1  FIFO holds 0 entries
ALMOST_EMPTY  output  1  COUNT <= AEMPTY_THR
COUNT  output  9  current occupancy, 0..256
OVERFLOW  output  1  sticky: write attempted while FULL
UNDERFLOW  output  1  sticky: read attempted while EMPTY

Behaviour:
- Reset (RST_N=0 at CLK rise) has priority over all other inputs. It clears:
  - wr_ptr, rd_ptr and COUNT to 0
  - RD_DATA to 0
  - OVERFLOW and UNDERFLOW to 0
  It sets EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0.
- Storage contents are not cleared by reset; they power up to 0. Reset mid-operation logically discards all stored entries.
- Write accepted = WR_EN & ~FULL. On acceptance: mem[wr_ptr] <= WR_DATA and wr_ptr increments.
- Read accepted = RD_EN & ~EMPTY. On acceptance: RD_DATA <= mem[rd_ptr] (asynchronous array read, then registered) and rd_ptr increments.
- Read latency: data is valid on RD_DATA one cycle after the RD_EN edge. It is standard mode, not first-word-fall-through.
- RD_DATA holds its value when no read is accepted.
- Pointers are 8 bits and wrap 255 -> 0 with no extra logic.
- COUNT update:
  - +1 on write-only
  - -1 on read-only
  - unchanged when both or neither are accepted
- All flags are registered and computed from the next COUNT, so they are exact in the cycle after the edge:
  - EMPTY = (COUNT==0)
  - FULL = (COUNT==256)
  - ALMOST_FULL = (COUNT>=AFULL_THR)
  - ALMOST_EMPTY = (COUNT<=AEMPTY_THR)
- Simultaneous WR_EN and RD_EN:
  - When EMPTY: write accepted, read rejected (no bypass). UNDERFLOW sets.
  - When FULL: read accepted, write rejected. OVERFLOW sets.
  - Otherwise both are accepted and COUNT is unchanged.
- No same-address read/write collision can occur. Equal pointers imply COUNT 0 or 256, where one side is always blocked.
- OVERFLOW sets on (WR_EN & FULL) and UNDERFLOW sets on (RD_EN & EMPTY). Both stay set until reset. A rejected access changes no other state.
- Must simulate cleanly under Verilator with -Wall. No X sources and no latches.

Test Plan:
- Reset then idle 5 cycles -> EMPTY=1, ALMOST_EMPTY=1, FULL=0, COUNT=0, RD_DATA=0, OVERFLOW=UNDERFLOW=0.
- Write 0x01..0x05 (5 cycles), then read 5 -> RD_DATA = 0x01..0x05, each one cycle after its RD_EN edge; COUNT ends 0, EMPTY=1.
- Write 256 entries (i & 0xFF) -> FULL=1 and COUNT=256 after the 256th edge; ALMOST_FULL=1 from COUNT=240. One more write -> OVERFLOW=1, COUNT stays 256. Read all -> data 0x00..0xFF in order.
- Fill to 256, then WR_EN=RD_EN=1 for one cycle -> read accepted (RD_DATA=first entry), write rejected, COUNT=255, OVERFLOW=1.
- From empty, WR_EN=RD_EN=1 with 0xA5 -> COUNT=1, RD_DATA unchanged, UNDERFLOW=1. Next cycle RD_EN -> RD_DATA=0xA5.
- Pointer wrap: 300 write/read pairs with one-entry lag -> data order preserved across the 255->0 wrap. Assert RST_N=0 at COUNT=100 -> COUNT=0, EMPTY=1 next cycle.
